// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480 timing, width helpers and payload structs.
package vga_pkg;

   localparam int unsigned VGA_640X480_H_ACTIVE = 640;
   localparam int unsigned VGA_640X480_H_FP     = 16;
   localparam int unsigned VGA_640X480_H_SYNC   = 96;
   localparam int unsigned VGA_640X480_H_BP     = 48;
   localparam int unsigned VGA_640X480_V_ACTIVE = 480;
   localparam int unsigned VGA_640X480_V_FP     = 10;
   localparam int unsigned VGA_640X480_V_SYNC   = 2;
   localparam int unsigned VGA_640X480_V_BP     = 33;

   // Counter width able to hold 0..total-1 (never narrower than one bit).
   function automatic int unsigned cnt_w(input int unsigned total);
      return (total < 2) ? 1 : $clog2(total);
   endfunction

   function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   // Sync/enable bundle carried down the lead pipeline.
   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } sync_t;

   // Default-width colour payload for 4-bit-per-channel DACs.
   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping 0..TOTAL-1 counter for one raster axis; wrap_c flags the enabled terminal count.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned TOTAL = 800
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   output logic [cnt_w(TOTAL)-1:0]   count,
   output logic                      wrap_c
);

   localparam int unsigned W = cnt_w(TOTAL);

   assign wrap_c = en && (count == W'(TOTAL - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (en) begin
         count <= wrap_c ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator with pixel-source lookahead and matched sync/blank delay.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned COLOR_W  = 4,
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACTIVE = VGA_640X480_H_ACTIVE,
   parameter int unsigned H_FP     = VGA_640X480_H_FP,
   parameter int unsigned H_SYNC   = VGA_640X480_H_SYNC,
   parameter int unsigned H_BP     = VGA_640X480_H_BP,
   parameter int unsigned V_ACTIVE = VGA_640X480_V_ACTIVE,
   parameter int unsigned V_FP     = VGA_640X480_V_FP,
   parameter int unsigned V_SYNC   = VGA_640X480_V_SYNC,
   parameter int unsigned V_BP     = VGA_640X480_V_BP,
   parameter logic        HS_POL   = 1'b0,
   parameter logic        VS_POL   = 1'b0,
   parameter int unsigned LEAD     = 1
) (
   input  logic                                                        clk_50,
   input  logic                                                        rst_n,
   output logic [cnt_w(axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP))-1:0]  pix_x,
   output logic [cnt_w(axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP))-1:0]  pix_y,
   output logic                                                        pix_req,
   input  logic [3*COLOR_W-1:0]                                        pix_rgb,
   output logic [COLOR_W-1:0]                                          vga_r,
   output logic [COLOR_W-1:0]                                          vga_g,
   output logic [COLOR_W-1:0]                                          vga_b,
   output logic                                                        vga_hs,
   output logic                                                        vga_vs,
   output logic                                                        vga_de,
   output logic                                                        frame_start,
   output logic                                                        line_start
);

   localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned HW      = cnt_w(H_TOTAL);
   localparam int unsigned VW      = cnt_w(V_TOTAL);
   localparam int unsigned DW      = cnt_w(CLK_DIV);

   if (CLK_DIV == 0 || LEAD == 0 || LEAD > 4 || COLOR_W == 0 ||
       H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_param
      $error("vga_timing_gen: illegal parameter set");
   end

   typedef struct packed {
      logic [COLOR_W-1:0] r;
      logic [COLOR_W-1:0] g;
      logic [COLOR_W-1:0] b;
   } rgb_t;

   logic [DW-1:0] div_cnt;
   logic          tick_c;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_wrap_c;
   logic          v_wrap_c;
   sync_t         raw_c;
   sync_t         last_c;
   rgb_t          rgb_in;

   // Pixel-rate enable from clk_50.
   assign tick_c = (div_cnt == DW'(CLK_DIV - 1));

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= tick_c ? '0 : div_cnt + DW'(1);
      end
   end

   vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
      .clk    (clk_50),
      .rst_n  (rst_n),
      .en     (tick_c),
      .count  (h_cnt),
      .wrap_c (h_wrap_c)
   );

   vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
      .clk    (clk_50),
      .rst_n  (rst_n),
      .en     (h_wrap_c),
      .count  (v_cnt),
      .wrap_c (v_wrap_c)
   );

   assign pix_x   = h_cnt;
   assign pix_y   = v_cnt;
   assign pix_req = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
   assign rgb_in  = pix_rgb;

   // vsync is decoded from the line count only, so it moves on the h wrap.
   always_comb begin
      raw_c    = '0;
      raw_c.hs = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
      raw_c.vs = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
      raw_c.de = pix_req;
   end

   // LEAD-1 stages here; the output register below is the final stage.
   if (LEAD == 1) begin : g_direct
      assign last_c = raw_c;
   end else begin : g_pipe
      sync_t sr [LEAD-1];

      always_ff @(posedge clk_50 or negedge rst_n) begin
         if (!rst_n) begin
            for (int unsigned i = 0; i < LEAD - 1; i++) sr[i] <= '0;
         end else if (tick_c) begin
            sr[0] <= raw_c;
            for (int unsigned i = 1; i < LEAD - 1; i++) sr[i] <= sr[i-1];
         end
      end

      assign last_c = sr[LEAD-2];
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_de      <= 1'b0;
         vga_hs      <= ~HS_POL;
         vga_vs      <= ~VS_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= h_wrap_c;
         frame_start <= v_wrap_c;
         if (tick_c) begin
            vga_de <= last_c.de;
            vga_hs <= last_c.hs ? HS_POL : ~HS_POL;
            vga_vs <= last_c.vs ? VS_POL : ~VS_POL;
            vga_r  <= last_c.de ? rgb_in.r : '0;
            vga_g  <= last_c.de ? rgb_in.g : '0;
            vga_b  <= last_c.de ? rgb_in.b : '0;
         end
      end
   end

endmodule
